fu_execute_unit: RTL

- One execution lane sitting between a reservation-station issue port and the result-broadcast network.
- Accepts one issued instruction per handshake and computes either the ALU result or, for load/store, the effective address.
- ALU results are driven as a wakeup broadcast (tag/value/ROB) and held until the broadcast arbiter grants them; load/store requests go to the LSU with a valid/ready handshake.
- FU_ready back-pressures the reservation station.

---
 rtl/fu_execute_unit_pkg.sv | 26 ++
 rtl/fu_execute_unit_if.sv | 45 ++++
 rtl/fu_execute_unit_alu_comb.sv | 26 ++
 rtl/fu_execute_unit.sv | 109 ++++++++++
 4 files changed

// File: rtl/fu_execute_unit_pkg.sv
// rtl/fu_execute_unit_pkg.sv - shared widths, ALU opcodes and lane state encoding
package exec_pkg;
  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int ROB_W = 6;
  localparam int OP_W  = 4;

  localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'b1001;
  localparam logic [OP_W-1:0] ALU_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_HOLD_WB = 2'd2,
    ST_HOLD_LS = 2'd3
  } state_e;
endpackage

// File: rtl/fu_execute_unit_if.sv
// rtl/fu_execute_unit_if.sv - issue, wakeup broadcast and LSU request bundle for one lane
interface fu_execute_unit_if;
  import exec_pkg::*;

  logic             issue_valid;
  logic             issue_is_LS;
  logic [TAG_W-1:0] issue_rd_tag;
  logic             issue_alusrc;
  logic [ROB_W-1:0] issue_rob_num;
  logic [XLEN-1:0]  issue_rs1_val;
  logic [XLEN-1:0]  issue_rs2_val;
  logic [XLEN-1:0]  issue_imm;
  logic [OP_W-1:0]  issue_alu_type;
  logic             FU_ready;

  logic             wakeup_valid;
  logic [TAG_W-1:0] wakeup_tag;
  logic [XLEN-1:0]  wakeup_val;
  logic [ROB_W-1:0] wakeup_rob_num;
  logic             wakeup_grant;

  logic             ls_req_valid;
  logic [XLEN-1:0]  ls_addr;
  logic [XLEN-1:0]  ls_store_data;
  logic [TAG_W-1:0] ls_rd_tag;
  logic [ROB_W-1:0] ls_rob_num;
  logic [OP_W-1:0]  ls_alu_type;
  logic             ls_req_ready;

  modport slave (
    input  issue_valid, issue_is_LS, issue_rd_tag, issue_alusrc, issue_rob_num,
           issue_rs1_val, issue_rs2_val, issue_imm, issue_alu_type,
           wakeup_grant, ls_req_ready,
    output FU_ready, wakeup_valid, wakeup_tag, wakeup_val, wakeup_rob_num,
           ls_req_valid, ls_addr, ls_store_data, ls_rd_tag, ls_rob_num, ls_alu_type
  );

  modport master (
    output issue_valid, issue_is_LS, issue_rd_tag, issue_alusrc, issue_rob_num,
           issue_rs1_val, issue_rs2_val, issue_imm, issue_alu_type,
           wakeup_grant, ls_req_ready,
    input  FU_ready, wakeup_valid, wakeup_tag, wakeup_val, wakeup_rob_num,
           ls_req_valid, ls_addr, ls_store_data, ls_rd_tag, ls_rob_num, ls_alu_type
  );
endinterface

// File: rtl/fu_execute_unit_alu_comb.sv
// rtl/fu_execute_unit_alu_comb.sv - single-cycle ALU opcodes; MUL and unused codes yield 0 here
module alu_comb
  import exec_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [OP_W-1:0] op_i,
  output logic [XLEN-1:0] result_o
);
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_ADD:  result_o = a_i + b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLL:  result_o = a_i << b_i[4:0];
      ALU_SRL:  result_o = a_i >> b_i[4:0];
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      default:  result_o = '0;
    endcase
  end
endmodule

// File: rtl/fu_execute_unit.sv
// rtl/fu_execute_unit.sv - execution lane: issue accept, MUL countdown, hold-until-taken result/LSU request
module fu_execute_unit
  import exec_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               reset,
  fu_execute_unit_if.slave   bus
);
  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q;
  logic [ROB_W-1:0] rob_q;
  logic [OP_W-1:0]  op_q;
  logic [XLEN-1:0]  val_q, addr_q, sdata_q, mul_a_q, mul_b_q;

  logic [XLEN-1:0] operand_b, alu_res;
  logic            fu_ready, accept, is_mul;

  assign operand_b = bus.issue_alusrc ? bus.issue_imm : bus.issue_rs2_val;
  assign is_mul    = (bus.issue_alu_type == ALU_MUL);

  alu_comb u_alu (
    .a_i      (bus.issue_rs1_val),
    .b_i      (operand_b),
    .op_i     (bus.issue_alu_type),
    .result_o (alu_res)
  );

  // A slot freed by a grant/accept this cycle can be refilled on the same edge.
  always_comb begin
    fu_ready = 1'b0;
    case (state_q)
      ST_IDLE:    fu_ready = 1'b1;
      ST_HOLD_WB: fu_ready = bus.wakeup_grant;
      ST_HOLD_LS: fu_ready = bus.ls_req_ready;
      default:    fu_ready = 1'b0;
    endcase
  end

  assign accept = bus.issue_valid && fu_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_BUSY: begin
        if (cnt_q == 4'd0) state_d = ST_HOLD_WB;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_HOLD_WB: if (bus.wakeup_grant) state_d = ST_IDLE;
      ST_HOLD_LS: if (bus.ls_req_ready) state_d = ST_IDLE;
      default:    state_d = state_q;
    endcase
    if (accept) begin
      if (bus.issue_is_LS) begin
        state_d = ST_HOLD_LS;
      end else if (is_mul) begin
        state_d = ST_BUSY;
        cnt_d   = 4'(MUL_LAT - 1);
      end else begin
        state_d = ST_HOLD_WB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      rob_q   <= '0;
      op_q    <= '0;
      val_q   <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        tag_q   <= bus.issue_rd_tag;
        rob_q   <= bus.issue_rob_num;
        op_q    <= bus.issue_alu_type;
        addr_q  <= bus.issue_rs1_val + bus.issue_imm;
        sdata_q <= bus.issue_rs2_val;
        mul_a_q <= bus.issue_rs1_val;
        mul_b_q <= operand_b;
        if (!bus.issue_is_LS && !is_mul) val_q <= alu_res;
      end else if (state_q == ST_BUSY && cnt_q == 4'd0) begin
        val_q <= mul_a_q * mul_b_q;
      end
    end
  end

  assign bus.FU_ready       = fu_ready;
  assign bus.wakeup_valid   = (state_q == ST_HOLD_WB);
  assign bus.wakeup_tag     = tag_q;
  assign bus.wakeup_val     = val_q;
  assign bus.wakeup_rob_num = rob_q;
  assign bus.ls_req_valid   = (state_q == ST_HOLD_LS);
  assign bus.ls_addr        = addr_q;
  assign bus.ls_store_data  = sdata_q;
  assign bus.ls_rd_tag      = tag_q;
  assign bus.ls_rob_num     = rob_q;
  assign bus.ls_alu_type    = op_q;
endmodule
